// File: rtl/harmonic_seq.sv
// Harmonic mixer sequencer: requests up to three harmonics from a source,
// scales and sums them, and emits one saturated sample per codec request.
module harmonic_seq (
  input  logic               clk,
  input  logic               reset,
  input  logic               weight_button,
  input  logic               generate_next,
  input  logic               h_valid,
  input  logic signed [15:0] h_sample,
  output logic               h_req,
  output logic [1:0]         h_sel,
  output logic [1:0]         weight,
  output logic signed [15:0] sample_out,
  output logic               sample_ready,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_weight, r_mode, r_sel;
  logic signed [17:0] r_acc, w_ext, w_gain, w_sum;
  logic signed [15:0] r_out, w_sat;
  logic               r_ovr;
  logic               w_last;

  assign w_ext  = {{2{h_sample[15]}}, h_sample};
  assign w_sum  = r_acc + w_gain;
  assign w_last = (r_sel == r_mode);

  always_comb begin
    w_gain = w_ext;
    case (r_sel)
      2'd1:    w_gain = w_ext >>> 1;
      2'd2:    w_gain = w_ext >>> 2;
      default: w_gain = w_ext;
    endcase
  end

  // Worst case |sum| is 1.75 * 2^15, so 18 bits never wrap before clamping.
  always_comb begin
    w_sat = w_sum[15:0];
    if (w_sum > 18'sd32767)
      w_sat = 16'sh7fff;
    else if (w_sum < -18'sd32768)
      w_sat = 16'sh8000;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (generate_next) w_state_nxt = REQ;
      REQ:     w_state_nxt = WAIT;
      WAIT:    if (h_valid) w_state_nxt = w_last ? DONE : REQ;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_weight <= 2'd0;
      r_mode   <= 2'd0;
      r_sel    <= 2'd0;
      r_acc    <= 18'sd0;
      r_out    <= 16'sd0;
      r_ovr    <= 1'b0;
    end else begin
      if (weight_button)
        r_weight <= (r_weight == 2'd2) ? 2'd0 : r_weight + 2'd1;
      if (generate_next && r_state != IDLE)
        r_ovr <= 1'b1;
      case (r_state)
        IDLE: if (generate_next) begin
          r_acc  <= 18'sd0;
          r_sel  <= 2'd0;
          r_mode <= r_weight;
        end
        // Result is registered on the way into DONE so it is visible with the pulse.
        WAIT: if (h_valid) begin
          r_acc <= w_sum;
          if (w_last) r_out <= w_sat;
          else        r_sel <= r_sel + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign h_req        = (r_state == REQ);
  assign h_sel        = r_sel;
  assign weight       = r_weight;
  assign sample_out   = r_out;
  assign sample_ready = (r_state == DONE);
  assign busy         = (r_state != IDLE);
  assign overrun      = r_ovr;

endmodule

// File: tb/tb_harmonic_seq.sv
// Randomized scoreboard bench for harmonic_seq with a behavioural mixing model
// and a harmonic source that answers h_req after a programmable delay.
module tb_harmonic_seq;

  logic               clk = 1'b0;
  logic               reset, weight_button, generate_next, h_valid;
  logic signed [15:0] h_sample;
  logic               h_req, sample_ready, busy, overrun;
  logic [1:0]         h_sel, weight;
  logic signed [15:0] sample_out;

  harmonic_seq dut (
    .clk(clk), .reset(reset), .weight_button(weight_button),
    .generate_next(generate_next), .h_valid(h_valid), .h_sample(h_sample),
    .h_req(h_req), .h_sel(h_sel), .weight(weight), .sample_out(sample_out),
    .sample_ready(sample_ready), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int val; int lat; int cyc; } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;
  int cyc = 0, n_ready = 0;
  int m_weight = 0;
  int cur_s[3];
  int src_delay = 0;
  int exp_sel = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model(input int mode, input int s0, input int s1, input int s2);
    int a;
    a = s0;
    if (mode >= 1) a += s1 >>> 1;
    if (mode >= 2) a += s2 >>> 2;
    if (a > 32767)  a = 32767;
    if (a < -32768) a = -32768;
    return a;
  endfunction

  // Harmonic source: answers each request after src_delay idle cycles.
  initial begin
    int sel;
    h_valid = 1'b0; h_sample = '0;
    forever begin
      @(negedge clk);
      h_valid = 1'b0;
      if (h_req) begin
        chk("h_sel_order", int'(h_sel), exp_sel);
        exp_sel++;
        sel = int'(h_sel);
        repeat (src_delay + 1) @(negedge clk);
        h_valid  = 1'b1;
        h_sample = 16'(cur_s[sel < 3 ? sel : 0]);
      end
    end
  end

  // Monitor: every sample_ready must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sample_ready) begin
        n_ready++;
        if (q.size() == 0) begin
          chk("unexpected_sample_ready", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sample_out", int'(sample_out), e.val);
          if (e.lat >= 0) chk("latency", cyc - e.cyc, e.lat);
        end
      end
    end
  end

  // All tasks start and end at a negedge.
  task automatic press();
    weight_button = 1'b1;
    m_weight = (m_weight + 1) % 3;
    @(negedge clk);
    weight_button = 1'b0;
  endtask

  task automatic issue(input bit with_btn);
    exp_t e;
    int mode;
    mode = m_weight;
    e.val = model(mode, cur_s[0], cur_s[1], cur_s[2]);
    e.lat = (src_delay == 0) ? 2 * (mode + 1) + 1 : -1;
    e.cyc = cyc;
    q.push_back(e);
    exp_sel = 0;
    generate_next = 1'b1;
    if (with_btn) begin
      weight_button = 1'b1;
      m_weight = (m_weight + 1) % 3;
    end
    @(negedge clk);
    generate_next = 1'b0;
    weight_button = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!sample_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) chk("sample_ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic set_s(input int a, input int b, input int c);
    cur_s[0] = a; cur_s[1] = b; cur_s[2] = c;
  endtask

  task automatic set_weight(input int w);
    while (m_weight != w) press();
  endtask

  initial begin
    int r0;
    set_s(0, 0, 0);
    reset = 1'b1; weight_button = 1'b1; generate_next = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_weight", int'(weight), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_h_req", int'(h_req), 0);
    chk("rst_sample_out", int'(sample_out), 0);
    chk("rst_sample_ready", int'(sample_ready), 0);
    reset = 1'b0; weight_button = 1'b0; generate_next = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);

    // Weight wrap then reset back to 0
    press(); chk("wrap1", int'(weight), 1);
    press(); chk("wrap2", int'(weight), 2);
    press(); chk("wrap3", int'(weight), 0);
    press(); chk("wrap4", int'(weight), 1);
    reset = 1'b1; @(negedge clk); reset = 1'b0; m_weight = 0;
    chk("wrap_rst", int'(weight), 0);
    @(negedge clk);

    // Mode 0, zero-wait source
    src_delay = 0; set_s(1000, 0, 0);
    issue(0); wait_done();

    // Mode 2 mix
    set_weight(2); set_s(1000, -400, 800);
    issue(0); wait_done();

    // Saturation both directions
    set_s(32767, 32767, 32767);   issue(0); wait_done();
    set_s(-32768, -32768, -32768); issue(0); wait_done();

    // Mode 1, slow source, button + extra generate_next during WAIT
    set_weight(1); set_s(1200, -600, 5000); src_delay = 5;
    r0 = n_ready;
    issue(0);
    @(negedge clk);
    chk("busy_in_seq", int'(busy), 1);
    weight_button = 1'b1; generate_next = 1'b1; m_weight = (m_weight + 1) % 3;
    @(negedge clk);
    weight_button = 1'b0; generate_next = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    chk("ovr_weight", int'(weight), 2);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_one_ready", n_ready - r0, 1);

    // Reset during WAIT of a mode 2 sequence
    set_weight(2); set_s(700, 700, 700); src_delay = 4;
    r0 = n_ready;
    issue(0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sample_out", int'(sample_out), 0);
    chk("abort_overrun", int'(overrun), 0);
    reset = 1'b0; m_weight = 0; q.delete();
    repeat (8) @(negedge clk);
    chk("abort_no_ready", n_ready - r0, 0);
    src_delay = 0; set_s(-1234, 0, 0);
    issue(0); wait_done();
    chk("abort_then_one_ready", n_ready - r0, 1);

    // Randomized sequences, back-to-back, occasional button in the issue cycle
    for (int it = 0; it < 40; it++) begin
      int np;
      np = $urandom_range(0, 2);
      for (int k = 0; k < np; k++) press();
      set_s($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
            $urandom_range(0, 65535) - 32768);
      if ($urandom_range(0, 7) == 0) set_s(32767, 32767, 32767);
      src_delay = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      issue($urandom_range(0, 3) == 0);
      wait_done();
      chk("rand_weight", int'(weight), m_weight);
    end
    chk("final_overrun", int'(overrun), 0);
    chk("final_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/harmonic_seq.md
HARMONIC_SEQ -- requirements
Module: harmonic_seq

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 weight_button  input  1  one-cycle, already-debounced pulse that advances the harmonic weight mode.
REQ-005 generate_next  input  1  one-cycle pulse from the codec requesting the next output sample.
REQ-006 h_valid  input  1  harmonic source returns a sample this cycle.
REQ-007 h_sample  input  16  signed harmonic sample; valid only when h_valid=1.
REQ-008 h_req  output  1  one-cycle request to the harmonic source.
REQ-009 h_sel  output  2  harmonic index for h_req: 0 = fundamental, 1 = 2nd harmonic, 2 = 3rd harmonic.
REQ-010 weight  output  2  current weight mode, 0..2.
REQ-011 sample_out  output  16  signed mixed sample; held between updates.
REQ-012 sample_ready  output  1  one-cycle pulse; sample_out is updated in the same cycle.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 overrun  output  1  sticky error flag.

Function
REQ-015 weight SHALL increment on each cycle with weight_button=1, in any state: 0->1->2->0 (wrap from 2 to 0).
REQ-016 Mode latch: on accepting generate_next, mode_act SHALL be set to the current weight; changes to weight during a sequence SHALL NOT affect that sequence.
REQ-017 Harmonic count N SHALL be mode_act+1 (mode 0: h_sel 0 only; mode 1: 0,1; mode 2: 0,1,2).
REQ-018 Gains: sel0 x1, sel1 arithmetic >>1, sel2 arithmetic >>2, each applied to the sign-extended sample.
REQ-019 Accumulator: 18-bit signed, cleared on sequence start; on completion it SHALL saturate to [-32768, 32767] into sample_out.
REQ-020 FSM states SHALL be IDLE, REQ, WAIT and DONE.
REQ-021 IDLE: generate_next=1 -> acc=0, h_sel=0, latch mode_act, go to REQ.
REQ-022 REQ: h_req=1 for exactly this cycle, then go to WAIT.
REQ-023 WAIT: hold h_sel; h_valid is sampled only in WAIT; ignore h_valid in all other states.
REQ-024 WAIT with h_valid=1: acc += gained h_sample; if h_sel = N-1 go to DONE, else increment h_sel and go to REQ.
REQ-025 WAIT with h_valid=0: remain in WAIT indefinitely (no timeout).
REQ-026 DONE: load sample_out, pulse sample_ready, go to IDLE.
REQ-027 Latency with a zero-wait source (h_valid the cycle after h_req): sample_ready SHALL occur 2N+1 cycles after the generate_next cycle (3, 5 or 7 cycles).
REQ-028 generate_next while busy=1 SHALL be ignored and SHALL set overrun=1.
REQ-029 overrun SHALL be cleared only by reset.
REQ-030 Back-to-back: a generate_next in the cycle after DONE SHALL be accepted normally.
REQ-031 Simultaneous weight_button and generate_next in IDLE: the sequence SHALL use the pre-increment weight, and weight SHALL increment.

Reset
REQ-032 While reset=1, the block SHALL set state=IDLE, weight=0, mode_act=0, acc=0, h_sel=0, and drive sample_out=0, sample_ready=0, h_req=0, busy=0, overrun=0.
REQ-033 Reset SHALL take priority over all inputs, including weight_button and generate_next in the same cycle.
REQ-034 Reset asserted mid-sequence SHALL abort the sequence with no sample_ready pulse; the first cycle after reset deasserts SHALL be IDLE.

Verification
REQ-035 Wrap: 4 weight_button pulses after reset -> weight reads 1, 2, 0, 1; then reset -> weight=0.
REQ-036 Mode 0, source returns 1000 one cycle after h_req -> single h_req with h_sel=0; sample_ready 3 cycles after generate_next; sample_out=1000.
REQ-037 Mode 2, samples 1000/-400/800, zero-wait source -> h_sel sequence 0,1,2; sample_out=1000-200+200=1000; sample_ready at cycle 7.
REQ-038 Mode 2, all samples 32767 -> sample_out=32767 (saturated); all samples -32768 -> sample_out=-32768.
REQ-039 Mode 1, h_valid delayed 5 cycles, with weight_button and a second generate_next pulsed during WAIT -> result uses mode 1; weight=2; overrun=1; exactly one sample_ready.
REQ-040 Reset pulsed during WAIT of a mode 2 sequence -> no sample_ready; sample_out=0; busy=0 the next cycle; a new sequence then completes normally.
